regs_wb_arbiter: RTL and testbench

- Write-side initiator for the CPU register file: merges single-cycle pipeline writeback with results from long-latency units (divider, late loads) into the one register-file write port.
- Pipeline results have priority. Multi-cycle results are buffered in a small FIFO and drained into idle write slots.
- Keeps a busy scoreboard of destination registers with outstanding multi-cycle operations, so the hazard logic can stall dependent reads.

---
 rtl/regs_wb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_regs_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_wb_arbiter.sv
// Register-file write arbiter: pipeline writeback first, buffered
// multi-cycle results drain into idle slots; tracks busy registers.
//
// Ports:
//   i_clk, i_rst (sync, active-high), i_ce (clock enable)
//   i_pipe_we/i_pipe_addr/i_pipe_dat : single-cycle writeback request
//   i_issue/i_issue_addr, o_issue_ready : multi-cycle op issue
//   i_mc_valid/o_mc_ready/i_mc_addr/i_mc_dat : multi-cycle result push
//   o_we/o_addr_wr/o_dat_wr : registered register-file write port
//   o_busy_mask : registers awaiting a multi-cycle result
//   o_err : sticky protocol violation flag
module regs_wb_arbiter #(
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_pipe_we,
    input  logic [4:0]  i_pipe_addr,
    input  logic [31:0] i_pipe_dat,
    input  logic        i_issue,
    input  logic [4:0]  i_issue_addr,
    output logic        o_issue_ready,
    input  logic        i_mc_valid,
    output logic        o_mc_ready,
    input  logic [4:0]  i_mc_addr,
    input  logic [31:0] i_mc_dat,
    output logic        o_we,
    output logic [4:0]  o_addr_wr,
    output logic [31:0] o_dat_wr,
    output logic [31:0] o_busy_mask,
    output logic        o_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(MAX_OUT + 1);

    logic [4:0]    r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_dat  [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_pend;
    logic [31:0]   r_busy;
    logic          r_we;
    logic [4:0]    r_addr;
    logic [31:0]   r_dat;
    logic          r_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_pipe_sel;
    logic          w_issue_ok;
    logic          w_err_evt;
    logic [4:0]    w_head_addr;
    logic [31:0]   w_head_dat;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] w_pend_nxt;
    logic [31:0]   w_busy_nxt;

    // Ready depends on occupancy only; a same-cycle pop never
    // opens a slot for a push.
    assign w_full        = (r_count == CW'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign o_mc_ready    = ~w_full;
    assign o_issue_ready = (r_pend != PW'(MAX_OUT));

    assign w_push     = i_mc_valid & ~w_full;
    // A pipeline write to x0 leaves the slot free for the FIFO.
    assign w_pipe_sel = i_pipe_we & (i_pipe_addr != 5'd0);
    assign w_pop      = ~w_pipe_sel & ~w_empty;
    assign w_issue_ok = i_issue & o_issue_ready;

    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_dat  = r_fifo_dat[r_rptr];

    assign w_err_evt = (i_issue & ~o_issue_ready)
                     | (i_issue & r_busy[i_issue_addr])
                     | (w_push & (r_pend == '0));

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Issue and pop on the same edge cancel; the guards keep the
    // counter inside 0..MAX_OUT.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_issue_ok && !w_pop) begin
            w_pend_nxt = r_pend + 1'b1;
        end else if (!w_issue_ok && w_pop && r_pend != '0) begin
            w_pend_nxt = r_pend - 1'b1;
        end
    end

    // Clear before set so a same-edge set on the popped address wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head_addr] = 1'b0;
        end
        if (w_issue_ok && i_issue_addr != 5'd0) begin
            w_busy_nxt[i_issue_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // FIFO storage needs no reset; occupancy is tracked by pointers.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_ce && w_push) begin
            r_fifo_addr[r_wptr] <= i_mc_addr;
            r_fifo_dat[r_wptr]  <= i_mc_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_pend  <= '0;
            r_busy  <= '0;
            r_err   <= 1'b0;
        end else if (i_ce) begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_pend  <= w_pend_nxt;
            r_busy  <= w_busy_nxt;
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_dat  <= '0;
        end else if (i_ce) begin
            if (w_pipe_sel) begin
                r_we   <= 1'b1;
                r_addr <= i_pipe_addr;
                r_dat  <= i_pipe_dat;
            end else if (!w_empty) begin
                // Results aimed at x0 still drain, but never write.
                r_we   <= (w_head_addr != 5'd0);
                r_addr <= w_head_addr;
                r_dat  <= w_head_dat;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign o_we        = r_we;
    assign o_addr_wr   = r_addr;
    assign o_dat_wr    = r_dat;
    assign o_busy_mask = r_busy;
    assign o_err       = r_err;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench for regs_wb_arbiter: directed steps followed
// by random traffic, compared against a queue-based reference model.
module tb_regs_wb_arbiter;

    localparam int DEPTH   = 2;
    localparam int MAX_OUT = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ce;
    logic        i_pipe_we;
    logic [4:0]  i_pipe_addr;
    logic [31:0] i_pipe_dat;
    logic        i_issue;
    logic [4:0]  i_issue_addr;
    logic        o_issue_ready;
    logic        i_mc_valid;
    logic        o_mc_ready;
    logic [4:0]  i_mc_addr;
    logic [31:0] i_mc_dat;
    logic        o_we;
    logic [4:0]  o_addr_wr;
    logic [31:0] o_dat_wr;
    logic [31:0] o_busy_mask;
    logic        o_err;

    always #5 i_clk = ~i_clk;

    regs_wb_arbiter #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce),
        .i_pipe_we(i_pipe_we), .i_pipe_addr(i_pipe_addr),
        .i_pipe_dat(i_pipe_dat),
        .i_issue(i_issue), .i_issue_addr(i_issue_addr),
        .o_issue_ready(o_issue_ready),
        .i_mc_valid(i_mc_valid), .o_mc_ready(o_mc_ready),
        .i_mc_addr(i_mc_addr), .i_mc_dat(i_mc_dat),
        .o_we(o_we), .o_addr_wr(o_addr_wr), .o_dat_wr(o_dat_wr),
        .o_busy_mask(o_busy_mask), .o_err(o_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [4:0]  q_a[$];
    logic [31:0] q_d[$];
    int          m_pend;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_dat;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_rst = 1'b0; i_ce = 1'b1;
        i_pipe_we = 1'b0; i_pipe_addr = '0; i_pipe_dat = '0;
        i_issue = 1'b0; i_issue_addr = '0;
        i_mc_valid = 1'b0; i_mc_addr = '0; i_mc_dat = '0;
    endtask

    // One clock: check ready flags, advance model, advance DUT, compare.
    task automatic step();
        bit          can_push;
        bit          can_issue;
        bit          popped;
        logic [4:0]  pa;
        can_push  = (q_a.size() < DEPTH);
        can_issue = (m_pend < MAX_OUT);
        popped    = 1'b0;
        chk("mc_ready", {31'd0, o_mc_ready}, {31'd0, can_push});
        chk("issue_ready", {31'd0, o_issue_ready}, {31'd0, can_issue});
        if (i_rst) begin
            q_a.delete(); q_d.delete();
            m_pend = 0; m_busy = '0; m_err = 1'b0;
            m_we = 1'b0; m_addr = '0; m_dat = '0;
        end else if (i_ce) begin
            if (i_issue && !can_issue) m_err = 1'b1;
            if (i_issue && m_busy[i_issue_addr]) m_err = 1'b1;
            if (i_mc_valid && can_push && m_pend == 0) m_err = 1'b1;
            if (i_pipe_we && i_pipe_addr != 5'd0) begin
                m_we = 1'b1; m_addr = i_pipe_addr; m_dat = i_pipe_dat;
            end else if (q_a.size() > 0) begin
                pa = q_a.pop_front();
                m_dat = q_d.pop_front();
                m_addr = pa;
                m_we = (pa != 5'd0);
                m_busy[pa] = 1'b0;
                popped = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (i_issue && can_issue) begin
                m_pend++;
                if (i_issue_addr != 5'd0) m_busy[i_issue_addr] = 1'b1;
            end
            if (popped && m_pend > 0) m_pend--;
            m_busy[0] = 1'b0;
            if (i_mc_valid && can_push) begin
                q_a.push_back(i_mc_addr);
                q_d.push_back(i_mc_dat);
            end
        end
        @(posedge i_clk);
        #1;
        chk("we", {31'd0, o_we}, {31'd0, m_we});
        chk("addr", {27'd0, o_addr_wr}, {27'd0, m_addr});
        chk("dat", o_dat_wr, m_dat);
        chk("busy", o_busy_mask, m_busy);
        chk("err", {31'd0, o_err}, {31'd0, m_err});
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        i_pipe_we = 1'b1; i_pipe_addr = a; i_pipe_dat = d;
    endtask

    task automatic issue(input logic [4:0] a);
        i_issue = 1'b1; i_issue_addr = a;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        i_mc_valid = 1'b1; i_mc_addr = a; i_mc_dat = d;
    endtask

    task automatic do_reset();
        idle(); i_rst = 1'b1; step(); idle();
    endtask

    logic [31:0] snap_dat;
    logic [4:0]  snap_addr;
    logic [31:0] snap_busy;
    logic        snap_we;

    initial begin
        idle();
        q_a.delete(); q_d.delete();
        m_pend = 0; m_busy = '0; m_we = 1'b0;
        m_addr = '0; m_dat = '0; m_err = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        do_reset();

        // Reset then idle
        step();
        chk("rst_we", {31'd0, o_we}, 32'd0);
        chk("rst_busy", o_busy_mask, 32'd0);
        chk("rst_mc_ready", {31'd0, o_mc_ready}, 32'd1);
        chk("rst_issue_ready", {31'd0, o_issue_ready}, 32'd1);
        chk("rst_err", {31'd0, o_err}, 32'd0);

        // Pipeline writes
        idle(); pipe(5'd5, 32'hDEADBEEF); step();
        chk("p5_we", {31'd0, o_we}, 32'd1);
        chk("p5_addr", {27'd0, o_addr_wr}, 32'd5);
        chk("p5_dat", o_dat_wr, 32'hDEADBEEF);
        idle(); pipe(5'd0, 32'h1111_1111); step();
        chk("p0_we", {31'd0, o_we}, 32'd0);

        // Issue x7, then its result drains two cycles after handshake
        idle(); issue(5'd7); step();
        chk("x7_busy", o_busy_mask, 32'h80);
        idle(); push(5'd7, 32'h12345678); step();
        chk("x7_we_early", {31'd0, o_we}, 32'd0);
        idle(); step();
        chk("x7_we", {31'd0, o_we}, 32'd1);
        chk("x7_addr", {27'd0, o_addr_wr}, 32'd7);
        chk("x7_dat", o_dat_wr, 32'h12345678);
        chk("x7_busy_clr", o_busy_mask, 32'd0);

        // Ordering: pipeline keeps priority, FIFO drains afterwards
        idle(); issue(5'd3); step();
        idle(); issue(5'd4); step();
        idle(); pipe(5'd1, 32'hA1); push(5'd3, 32'hC3); step();
        chk("ord1", {27'd0, o_addr_wr}, 32'd1);
        idle(); pipe(5'd2, 32'hA2); push(5'd4, 32'hC4); step();
        chk("ord2", {27'd0, o_addr_wr}, 32'd2);
        chk("full_mc_ready", {31'd0, o_mc_ready}, 32'd0);
        idle(); pipe(5'd9, 32'hA9); step();
        chk("ord9", {27'd0, o_addr_wr}, 32'd9);
        idle(); step();
        chk("ord3", {27'd0, o_addr_wr}, 32'd3);
        chk("ord3_dat", o_dat_wr, 32'hC3);
        idle(); step();
        chk("ord4", {27'd0, o_addr_wr}, 32'd4);
        chk("ord4_dat", o_dat_wr, 32'hC4);
        chk("drain_mc_ready", {31'd0, o_mc_ready}, 32'd1);

        // Pending limit and over-issue error
        for (int k = 0; k < MAX_OUT; k++) begin
            idle(); issue(5'(10 + k)); step();
        end
        chk("lim_ready", {31'd0, o_issue_ready}, 32'd0);
        chk("lim_err0", {31'd0, o_err}, 32'd0);
        idle(); issue(5'd14); step();
        chk("over_err", {31'd0, o_err}, 32'd1);
        chk("over_busy14", {31'd0, o_busy_mask[14]}, 32'd0);
        chk("over_ready", {31'd0, o_issue_ready}, 32'd0);

        // Re-issue to a busy register
        do_reset();
        idle(); issue(5'd10); step();
        chk("reiss_err0", {31'd0, o_err}, 32'd0);
        idle(); issue(5'd10); step();
        chk("reiss_err", {31'd0, o_err}, 32'd1);

        // Clock-enable freeze with two entries pending, then reset
        do_reset();
        idle(); issue(5'd20); step();
        idle(); issue(5'd21); step();
        idle(); pipe(5'd1, 32'hB1); push(5'd20, 32'hD20); step();
        idle(); pipe(5'd2, 32'hB2); push(5'd21, 32'hD21); step();
        snap_we = o_we; snap_addr = o_addr_wr;
        snap_dat = o_dat_wr; snap_busy = o_busy_mask;
        for (int k = 0; k < 3; k++) begin
            idle(); i_ce = 1'b0;
            pipe(5'd6, 32'hFFFF_0000); issue(5'd8);
            push(5'd9, 32'h5A5A_5A5A);
            step();
            chk("frz_we", {31'd0, o_we}, {31'd0, snap_we});
            chk("frz_addr", {27'd0, o_addr_wr}, {27'd0, snap_addr});
            chk("frz_dat", o_dat_wr, snap_dat);
            chk("frz_busy", o_busy_mask, snap_busy);
        end
        idle(); i_ce = 1'b0; i_rst = 1'b1; step();
        chk("frz_rst_we", {31'd0, o_we}, 32'd0);
        chk("frz_rst_busy", o_busy_mask, 32'd0);
        idle(); step();
        chk("no_stale_we", {31'd0, o_we}, 32'd0);
        chk("no_stale_ready", {31'd0, o_mc_ready}, 32'd1);
        idle(); step();
        chk("no_stale_we2", {31'd0, o_we}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            i_rst = ($urandom_range(0, 59) == 0);
            i_ce  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) begin
                pipe(($urandom_range(0, 5) == 0) ? 5'd0
                     : 5'($urandom_range(1, 31)), $urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                issue(5'($urandom_range(0, 31)));
            end
            if ($urandom_range(0, 2) == 0) begin
                push(($urandom_range(0, 7) == 0) ? 5'd0
                     : 5'($urandom_range(1, 31)), $urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
